// File: rtl/product_bcd_converter_pkg.sv
// Shared definitions for the product binary-to-BCD converter: FSM encoding and
// the double-dabble digit adjust constants.
package product_bcd_converter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_e;

    localparam int BCD_W      = 4;
    localparam int ADJ_THRESH = 5;
    localparam int ADJ_OFFSET = 3;

endpackage

// File: rtl/product_bcd_converter_bcd_digit_adjust.sv
// Combinational double-dabble cell: a BCD digit of 5 or more gets 3 added so the
// following left shift carries correctly into the next decimal digit.
module bcd_digit_adjust
    import product_bcd_converter_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i >= 4'(ADJ_THRESH)) ? (digit_i + 4'(ADJ_OFFSET)) : digit_i;

endmodule

// File: rtl/product_bcd_converter.sv
// Sequential shift-add-3 binary-to-BCD converter for the multiplier product;
// one bit per clock, result published with a one-cycle done pulse.
module product_bcd_converter
    import product_bcd_converter_pkg::*;
#(
    parameter int IN_W   = 16,
    parameter int DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [IN_W-1:0]           bin_in,
    output logic                      busy,
    output logic                      done,
    output logic [BCD_W*DIGITS-1:0]   bcd_out
);

    localparam int SR_W  = BCD_W * DIGITS;
    localparam int CNT_W = $clog2(IN_W + 1);

    conv_state_e        state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IN_W-1:0]    bin_sr_q, bin_sr_d;
    logic [SR_W-1:0]    bcd_sr_q, bcd_sr_d;
    logic [SR_W-1:0]    bcd_out_q, bcd_out_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic [SR_W-1:0]    bcd_adj;
    logic               unused_adj_msb;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adjust u_adj (
            .digit_i (bcd_sr_q[g*BCD_W +: BCD_W]),
            .digit_o (bcd_adj[g*BCD_W +: BCD_W])
        );
    end

    // With enough digits the top adjusted bit is always zero and falls off the shift.
    assign unused_adj_msb = bcd_adj[SR_W-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bin_sr_q  <= '0;
            bcd_sr_q  <= '0;
            bcd_out_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bin_sr_q  <= bin_sr_d;
            bcd_sr_q  <= bcd_sr_d;
            bcd_out_q <= bcd_out_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bin_sr_d  = bin_sr_q;
        bcd_sr_d  = bcd_sr_q;
        bcd_out_d = bcd_out_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_sr_d = bin_in;
                    bcd_sr_d = '0;
                    cnt_d    = CNT_W'(IN_W);
                    busy_d   = 1'b1;
                    state_d  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bcd_sr_d = {bcd_adj[SR_W-2:0], bin_sr_q[IN_W-1]};
                bin_sr_d = {bin_sr_q[IN_W-2:0], 1'b0};
                cnt_d    = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                bcd_out_d = bcd_sr_q;
                done_d    = 1'b1;
                busy_d    = 1'b0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign bcd_out = bcd_out_q;

endmodule

// File: tb/tb_product_bcd_converter.sv
// Randomized self-checking bench for product_bcd_converter against a decimal
// reference model (repeated divide-by-ten).
module tb_product_bcd_converter;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] bin_in;
    logic        busy;
    logic        done;
    logic [19:0] bcd_out;

    int checks   = 0;
    int failures = 0;

    product_bcd_converter #(.IN_W(16), .DIGITS(5)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .bcd_out (bcd_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] dec_model(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic digits_ok(input logic [19:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        end
        return ok;
    endfunction

    // One conversion: optional bin_in change and start poke while busy.
    task automatic conv(input logic [15:0] v, input logic [15:0] alt, input bit chg,
                        input bit poke, input int ncyc);
        int lat, busy_cnt, dones;
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        busy_cnt = busy ? 1 : 0;
        lat      = -1;
        dones    = 0;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            #1;
            if (chg && n == 3) bin_in = alt;
            start = (poke && n == 5) ? 1'b1 : 1'b0;
            if (busy) busy_cnt++;
            if (done) begin
                dones++;
                if (lat < 0) begin
                    lat = n;
                    chk("bcd_value", 32'(bcd_out), 32'(dec_model(32'(v))));
                    chk("digits_le9", 32'(digits_ok(bcd_out)), 32'd1);
                end
            end
        end
        start = 1'b0;
        chk("done_latency", 32'(lat), 32'd17);
        chk("busy_cycles", 32'(busy_cnt), 32'd17);
        chk("done_count", 32'(dones), 32'd1);
    endtask

    initial begin
        logic [15:0] vals [4];
        int          idx, last_t, stable_bad, ndone;
        logic [7:0]  a, b;

        rst_n  = 1'b0;
        start  = 1'b0;
        bin_in = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        conv(16'd40, 16'd0, 1'b0, 1'b0, 24);
        conv(16'd3465, 16'd272, 1'b1, 1'b0, 24);
        conv(16'd272, 16'd0, 1'b0, 1'b0, 24);
        conv(16'd0, 16'd0, 1'b0, 1'b0, 24);
        conv(16'hFFFF, 16'd0, 1'b0, 1'b0, 24);
        chk("max_value", 32'(bcd_out), 32'h65535);
        conv(16'd12345, 16'd0, 1'b0, 1'b1, 45);

        // start held high: back-to-back conversions, bin_in refreshed after each done
        vals[0] = 16'(a_rand()); vals[1] = 16'(a_rand());
        vals[2] = 16'(a_rand()); vals[3] = 16'(a_rand());
        @(negedge clk);
        bin_in     = vals[0];
        start      = 1'b1;
        idx        = 0;
        last_t     = -1;
        stable_bad = 0;
        for (int t = 0; t < 80 && idx < 3; t++) begin
            @(posedge clk);
            #1;
            if (done) begin
                chk("hold_bcd", 32'(bcd_out), 32'(dec_model(32'(vals[idx]))));
                if (last_t >= 0) chk("hold_gap", 32'(t - last_t), 32'd18);
                last_t = t;
                idx++;
                bin_in = vals[idx];
            end else if (idx > 0 && bcd_out !== dec_model(32'(vals[idx-1]))) begin
                stable_bad++;
            end
        end
        start = 1'b0;
        chk("hold_ndone", 32'(idx), 32'd3);
        chk("hold_stable", 32'(stable_bad), 32'd0);
        repeat (20) @(posedge clk);

        // reset mid-conversion, not aligned to the clock
        @(negedge clk);
        bin_in = 16'd9999;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_bcd", 32'(bcd_out), 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int t = 0; t < 30; t++) begin
            @(posedge clk);
            #1;
            if (done || busy) ndone++;
        end
        chk("midrst_no_done", 32'(ndone), 32'd0);

        // random 8x8 products
        for (int k = 0; k < 120; k++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            conv(16'(a) * 16'(b), 16'(a_rand()), 1'b1, 1'b0, 20);
        end
        conv(16'd65025, 16'd0, 1'b0, 1'b0, 20);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    function automatic int unsigned a_rand();
        return $urandom_range(0, 65535);
    endfunction

endmodule
